uart_tx: RTL

// UART serial transmitter; consumes the baud_tick strobe from baud_rate_generator_tx.

---
 rtl/uart_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter. Takes one word per valid/ready handshake and
// shifts it out LSB-first as start, data, optional parity and stop bits.
// Each bit is held for exactly one baud_tick period.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int   CW      = $clog2(DATA_BITS);
  localparam logic PAR_ODD = 1'(PARITY_ODD != 0);
  localparam logic PAR_ON  = 1'(PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;

  // State and datapath registers; reset drops the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; every bit boundary waits for baud_tick. SYNC exists so
  // the start bit always begins on a tick strictly after the accept edge.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d    = tx_data;
          par_d      = (^tx_data) ^ PAR_ODD;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          ready_d    = 1'b0;
          state_d    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
            if (PAR_ON) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;
  assign tx_busy  = (state_q != S_IDLE);

endmodule
